embed_fetch: RTL and testbench

//  Token-to-vector fetch stage between the token source and the tensor core datapath.
//  - Accepts a token ID on a valid/ready handshake.
//  - Reads the token's VEC_LEN consecutive words from the vocab sram, which is pre-loaded with the embedding table.
//  - Presents the words as one packed vector on a valid/ready output.
//  - Drives the sram read port directly. Read-only: writes are never issued.

---
 rtl/tensor_core_pkg.sv | 17 +
 rtl/embed_fetch.sv | 85 ++++++++
 tb/tb_embed_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// rtl/tensor_core_pkg.sv - shared types and default widths for the tensor core fetch path
package tensor_core_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_VEC_LEN    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/embed_fetch.sv
// rtl/embed_fetch.sv - token-to-vector fetch: reads VEC_LEN sram words per token id
// Issue and capture overlap; a one-cycle delayed strobe lands each sram word in its slot.
module embed_fetch
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int VEC_LEN    = DEF_VEC_LEN,
  localparam int TOK_WIDTH = ADDR_WIDTH - $clog2(VEC_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tok_valid,
  output logic                          tok_ready,
  input  logic [TOK_WIDTH-1:0]          tok_id,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  output logic [VEC_LEN*DATA_WIDTH-1:0] vec_data
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  fetch_state_t          state;
  logic [TOK_WIDTH-1:0]  tok_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_d;
  logic                  issue_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign tok_ready = (state == IDLE);
  assign vec_valid = (state == HOLD);
  assign sram_cs   = (state == READ);
  assign sram_we   = 1'b0;
  assign sram_din  = '0;
  // addr_q keeps the last issued address visible while the sram is deselected
  assign sram_addr = sram_cs ? {tok_q, idx} : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tok_q  <= '0;
      idx    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tok_valid) begin
            tok_q <= tok_id;
            idx   <= '0;
            state <= READ;
          end
        end
        READ: begin
          addr_q <= {tok_q, idx};
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: state <= HOLD;
        HOLD: begin
          if (vec_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_d  <= 1'b0;
      idx_d    <= '0;
      vec_data <= '0;
    end else begin
      issue_d <= sram_cs;
      idx_d   <= idx;
      if (issue_d) vec_data[idx_d*DATA_WIDTH +: DATA_WIDTH] <= sram_dout;
    end
  end

endmodule

// File: tb/tb_embed_fetch.sv
// tb/tb_embed_fetch.sv - randomized and directed bench for embed_fetch against a vocab-table model
module tb_embed_fetch;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int VL = 4;
  localparam int TW = AW - $clog2(VL);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tok_valid;
  logic             tok_ready;
  logic [TW-1:0]    tok_id;
  logic             sram_cs;
  logic             sram_we;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_din;
  logic [DW-1:0]    sram_dout;
  logic             vec_valid;
  logic             vec_ready;
  logic [VL*DW-1:0] vec_data;

  int n_vec = 0;
  int n_err = 0;

  embed_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VEC_LEN(VL)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_id(tok_id),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data)
  );

  always #5 clk = ~clk;

  // vocab sram, pre-loaded with mem[i] = 0x10 + i
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = DW'(16 + i);
  always @(posedge clk) if (sram_cs) sram_dout <= mem[sram_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VL*DW-1:0] ref_vec(input int t);
    logic [VL*DW-1:0] v;
    for (int j = 0; j < VL; j++) v[j*DW +: DW] = DW'(16 + t*VL + j);
    return v;
  endfunction

  // scoreboard / protocol monitor, sampled mid-cycle
  int              exp_q[$];
  logic [63:0]     got_q[$];
  int              acc_cnt = 0;
  int              cur_tok = 0;
  int              cs_k = 0;
  int              lat = -1;
  logic            prev_vv = 1'b0;
  logic            prev_hs = 1'b0;
  logic [VL*DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cs_k = 0;
      lat = -1;
      prev_vv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk("sram_we", 64'(sram_we), 64'd0);
      chk("sram_din", 64'(sram_din), 64'd0);
      if (sram_cs) begin
        chk("cs_window", 64'(cs_k < VL), 64'd1);
        chk("sram_addr", 64'(sram_addr), 64'(cur_tok*VL + cs_k));
        cs_k++;
      end
      if (lat >= 0) lat++;
      if (vec_valid && !prev_vv) begin
        chk("latency", 64'(lat), 64'(VL + 2));
        chk("cs_cycles", 64'(cs_k), 64'(VL));
        lat = -1;
      end
      if (vec_valid && prev_vv && !prev_hs) chk("hold_stable", 64'(vec_data), 64'(prev_data));
      if (vec_valid) chk("tok_ready_busy", 64'(tok_ready), 64'd0);
      if (vec_valid && vec_ready) begin
        if (exp_q.size() == 0) chk("unexpected_vec", 64'd1, 64'd0);
        else begin
          chk("vec_data", 64'(vec_data), 64'(ref_vec(exp_q.pop_front())));
          got_q.push_back(64'(vec_data));
        end
      end
      if (tok_valid && tok_ready) begin
        exp_q.push_back(int'(tok_id));
        cur_tok = int'(tok_id);
        cs_k = 0;
        lat = 0;
        acc_cnt++;
      end
      prev_vv = vec_valid;
      prev_hs = vec_valid && vec_ready;
      prev_data = vec_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input int t);
    int n = 0;
    tok_id = TW'(t);
    tok_valid = 1'b1;
    while (!tok_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
    step();
    tok_valid = 1'b0;
  endtask

  task automatic wait_vec();
    int n = 0;
    while (!vec_valid && n < 100) begin step(); n++; end
    if (n >= 100) chk("vec_timeout", 64'(n), 64'd0);
  endtask

  task automatic pulse_ready();
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, gbase, last_acc, n;
    rst_n = 1'b0;
    tok_valid = 1'b0;
    tok_id = '0;
    vec_ready = 1'b0;
    repeat (3) step();
    chk("rst_tok_ready", 64'(tok_ready), 64'd1);
    chk("rst_sram_cs", 64'(sram_cs), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_vec_valid", 64'(vec_valid), 64'd0);
    chk("rst_vec_data", 64'(vec_data), 64'd0);
    rst_n = 1'b1;
    step();

    // token 2: addresses 8..11, vector 0x1B1A1918
    send_tok(2);
    wait_vec();
    chk("t1_vec", 64'(vec_data), 64'h1B1A1918);
    pulse_ready();
    chk("t1_idle_ready", 64'(tok_ready), 64'd1);
    chk("t1_valid_drop", 64'(vec_valid), 64'd0);

    // backpressure: HOLD kept for 10 cycles
    send_tok(3);
    wait_vec();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_valid", 64'(vec_valid), 64'd1);
      chk("t2_data", 64'(vec_data), 64'h1F1E1D1C);
      chk("t2_tok_ready", 64'(tok_ready), 64'd0);
    end
    pulse_ready();
    chk("t2_idle_ready", 64'(tok_ready), 64'd1);
    chk("t2_data_retained", 64'(vec_data), 64'h1F1E1D1C);

    // back-to-back with tok_valid held high, downstream always ready
    vec_ready = 1'b1;
    base = acc_cnt;
    gbase = got_q.size();
    tok_id = TW'(0);
    tok_valid = 1'b1;
    n = 0;
    while (acc_cnt == base && n < 100) begin step(); n++; end
    tok_id = TW'(1);
    while (acc_cnt < base + 2 && n < 100) begin step(); n++; end
    if (n >= 100) chk("t3_accept_timeout", 64'(n), 64'd0);
    repeat (4) step();
    tok_valid = 1'b0;
    n = 0;
    while (got_q.size() < gbase + 2 && n < 50) begin step(); n++; end
    chk("t3_accepts", 64'(acc_cnt - base), 64'd2);
    if (got_q.size() >= gbase + 2) begin
      chk("t3_vec0", got_q[gbase], 64'h13121110);
      chk("t3_vec1", got_q[gbase+1], 64'h17161514);
    end else chk("t3_vec_count", 64'(got_q.size() - gbase), 64'd2);
    vec_ready = 1'b0;
    step();

    // asynchronous reset in the middle of READ
    send_tok(2);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t4_tok_ready", 64'(tok_ready), 64'd1);
    chk("t4_sram_cs", 64'(sram_cs), 64'd0);
    chk("t4_sram_addr", 64'(sram_addr), 64'd0);
    chk("t4_vec_valid", 64'(vec_valid), 64'd0);
    chk("t4_vec_data", 64'(vec_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    send_tok(1);
    wait_vec();
    chk("t4_vec", 64'(vec_data), 64'h17161514);
    pulse_ready();

    // randomized traffic with random backpressure
    last_acc = acc_cnt;
    for (int c = 0; c < 400; c++) begin
      vec_ready = ($urandom_range(0, 3) != 0);
      if (acc_cnt != last_acc) begin
        tok_valid = 1'b0;
        last_acc = acc_cnt;
      end
      if (!tok_valid && $urandom_range(0, 1) == 1) begin
        tok_valid = 1'b1;
        tok_id = TW'($urandom_range(0, 2**TW - 1));
      end
      step();
    end
    if (acc_cnt != last_acc) tok_valid = 1'b0;
    if (tok_valid && !tok_ready) tok_valid = 1'b0;
    vec_ready = 1'b1;
    step();
    tok_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !tok_ready) && n < 60) begin step(); n++; end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_activity", 64'(acc_cnt > 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
